// File: rtl/key_ctrl_pkg.sv
// key_ctrl_pkg: shared types and default sizes for the key load controller.
//   state_t      : controller states (CHECK only reachable with KEY_LOAD_CHECKSUM_EN)
//   *_DEF params : default key/word widths, derived word count and counter width
package key_ctrl_pkg;
  localparam int KEY_W_DEF     = 128;
  localparam int WORD_W_DEF    = 32;
  localparam int NUM_WORDS_DEF = KEY_W_DEF / WORD_W_DEF;
  localparam int CNT_W_DEF     = $clog2(NUM_WORDS_DEF + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    COMMIT  = 2'd3
  } state_t;
endpackage

// File: rtl/key_word_assembler.sv
// key_word_assembler: shifts incoming words into a KEY_W buffer, counts them
// and (with KEY_LOAD_CHECKSUM_EN) keeps a running XOR plus the trailing
// checksum word.
//   clk, rst  : clock, synchronous active-low reset
//   clear     : drop buffer, counter and checksum state
//   shift     : accept data this cycle
//   data      : incoming word
//   full      : the word accepted this cycle (if any) is the final one
//   key_nxt   : buffer contents as they stand after this cycle's shift
//   chk_ok    : trailing word equals XOR of key words (checksum build only)
module key_word_assembler
  import key_ctrl_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              full,
`ifdef KEY_LOAD_CHECKSUM_EN
  output logic              chk_ok,
`endif
  output logic [KEY_W-1:0]  key_nxt
);
  localparam int NUM_WORDS = KEY_W / WORD_W;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
`ifdef KEY_LOAD_CHECKSUM_EN
  localparam int TARGET = NUM_WORDS + 1;
`else
  localparam int TARGET = NUM_WORDS;
`endif

  logic [KEY_W-1:0] key_buf;
  logic [CNT_W-1:0] cnt;
  logic             key_shift;

  // Only the first NUM_WORDS words are key material; a trailing checksum
  // word is routed to its own register instead.
  assign key_shift = shift && (cnt < CNT_W'(NUM_WORDS));
  assign full      = (cnt == CNT_W'(TARGET - 1));
  assign key_nxt   = key_shift ? {key_buf[KEY_W-WORD_W-1:0], data} : key_buf;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      key_buf <= '0;
      cnt     <= '0;
    end else if (shift) begin
      cnt     <= cnt + CNT_W'(1);
      key_buf <= key_nxt;
    end
  end

`ifdef KEY_LOAD_CHECKSUM_EN
  logic [WORD_W-1:0] xor_acc;
  logic [WORD_W-1:0] chk_word;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      xor_acc  <= '0;
      chk_word <= '0;
    end else if (key_shift) begin
      xor_acc  <= xor_acc ^ data;
    end else if (shift) begin
      chk_word <= data;
    end
  end

  assign chk_ok = (chk_word == xor_acc);
`endif
endmodule

// File: rtl/key_load_ctrl.sv
// key_load_ctrl: sequences a word-stream key load into the key register with
// a single write strobe, a sticky lock and a zeroize command.
// Optional feature macro: KEY_LOAD_CHECKSUM_EN (adds a trailing XOR checksum
// word and a CHECK state).
//   clk, rst             : clock, synchronous active-low reset
//   start                : begin a load (ignored while busy)
//   wr_valid/wr_data/wr_ready : word input handshake
//   lock                 : set sticky lock; aborts a load in progress
//   zeroize              : write an all-zero key; highest priority
//   busy, done, err, locked : status (all registered)
//   ks_we, ks_wdata      : key register write port; data is 0 unless ks_we
module key_load_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_valid,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              lock,
  input  logic              zeroize,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              locked,
  output logic              ks_we,
  output logic [KEY_W-1:0]  ks_wdata
);
  state_t           state;
  logic             in_load;
  logic             shift;
  logic             clear;
  logic             full;
  logic [KEY_W-1:0] key_nxt;
`ifdef KEY_LOAD_CHECKSUM_EN
  logic             chk_ok;
`endif

  assign in_load = (state == COLLECT) || (state == CHECK);
  // Zeroize and lock both pre-empt word acceptance in the same cycle.
  assign shift   = wr_valid & wr_ready & ~zeroize & ~lock;
  assign clear   = zeroize | (in_load & lock) | (state == COMMIT) |
                   (state == CHECK) | ((state == IDLE) & start & ~locked);

  key_word_assembler #(.KEY_W(KEY_W), .WORD_W(WORD_W)) u_asm (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .shift   (shift),
    .data    (wr_data),
    .full    (full),
`ifdef KEY_LOAD_CHECKSUM_EN
    .chk_ok  (chk_ok),
`endif
    .key_nxt (key_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      locked   <= 1'b0;
      ks_we    <= 1'b0;
      ks_wdata <= '0;
    end else begin
      ks_we    <= 1'b0;
      ks_wdata <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      locked   <= locked | lock;
      if (zeroize) begin
        // Silent abort of anything in flight; the strobe carries zeros.
        state    <= IDLE;
        wr_ready <= 1'b0;
        busy     <= 1'b0;
        ks_we    <= 1'b1;
        done     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (locked) begin
                err <= 1'b1;
              end else begin
                state    <= COLLECT;
                wr_ready <= 1'b1;
                busy     <= 1'b1;
              end
            end
          end
          COLLECT: begin
            if (lock) begin
              state    <= IDLE;
              wr_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else if (shift && full) begin
              wr_ready <= 1'b0;
`ifdef KEY_LOAD_CHECKSUM_EN
              state    <= CHECK;
`else
              // Capture the key including the word landing this cycle.
              state    <= COMMIT;
              ks_we    <= 1'b1;
              ks_wdata <= key_nxt;
              done     <= 1'b1;
`endif
            end
          end
`ifdef KEY_LOAD_CHECKSUM_EN
          CHECK: begin
            if (lock || !chk_ok) begin
              state <= IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              state    <= COMMIT;
              ks_we    <= 1'b1;
              ks_wdata <= key_nxt;
              done     <= 1'b1;
            end
          end
`endif
          COMMIT: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            wr_ready <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_key_load_ctrl.sv
// tb_key_load_ctrl: directed stimulus with a scoreboard of expected key
// writes and expected error pulses; a negedge monitor checks DUT outputs.
module tb_key_load_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         wr_valid = 1'b0;
  logic [31:0]  wr_data = '0;
  logic         wr_ready;
  logic         lock = 1'b0;
  logic         zeroize = 1'b0;
  logic         busy, done, err, locked, ks_we;
  logic [127:0] ks_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] exp_wr[$];
  int           exp_err[$];

  always #5 clk = ~clk;

  key_load_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .lock(lock), .zeroize(zeroize),
    .busy(busy), .done(done), .err(err), .locked(locked),
    .ks_we(ks_we), .ks_wdata(ks_wdata)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the next expected write, every err
  // pulse must have been announced by the stimulus.
  always @(negedge clk) begin
    if (rst) begin
      chk("done_eq_we", {127'd0, done}, {127'd0, ks_we});
      if (!ks_we) begin
        chk("wdata_zero_idle", ks_wdata, 128'd0);
      end else if (exp_wr.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_we: got %h want no write", ks_wdata);
      end else begin
        chk("ks_wdata", ks_wdata, exp_wr.pop_front());
      end
      if (err) begin
        chk("err_expected", {127'd0, exp_err.size() != 0}, 128'd1);
        if (exp_err.size() != 0) void'(exp_err.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = w;
    while (!wr_ready && n < 20) begin
      tick();
      n++;
    end
    if (!wr_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL word_timeout: got wr_ready=0 want 1");
    end
    tick();
    wr_valid = 1'b0;
    wr_data  = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_ready_after_start", {126'd0, busy, wr_ready}, 128'd3);
  endtask

  // Sends nw key words (plus the checksum word when the feature is on and
  // the full key was sent).
  task automatic send_key(input logic [127:0] k, input int nw, input bit gaps,
                          input bit bad_sum);
    logic [31:0] x = '0;
    for (int i = 0; i < nw; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      send_word(k[127-32*i -: 32]);
      x ^= k[127-32*i -: 32];
    end
`ifdef KEY_LOAD_CHECKSUM_EN
    if (nw == 4) send_word(bad_sum ? ~x : x);
`else
    if (bad_sum) x = '0;
`endif
  endtask

  task automatic chk_reset_state(input string name);
    chk(name, {122'd0, wr_ready, busy, done, err, locked, ks_we}, 128'd0);
    chk({name, "_wdata"}, ks_wdata, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k1 = 128'h11111111_22222222_33333333_44444444;
    logic [127:0] k2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    logic [127:0] k3 = 128'h0BADF00D_A5A5A5A5_5A5A5A5A_FFFF0000;

    repeat (3) tick();
    chk_reset_state("reset");
    rst = 1'b1;
    tick();

    // Basic back-to-back load.
    exp_wr.push_back(k1);
    do_start();
    send_key(k1, 4, 1'b0, 1'b0);
`ifdef KEY_LOAD_CHECKSUM_EN
    tick();
`endif
    chk("we_after_last", {127'd0, ks_we}, 128'd1);
    tick();
    chk("busy_drop", {127'd0, busy}, 128'd0);

    // Gapped words, same assembly rule.
    exp_wr.push_back(k2);
    do_start();
    send_key(k2, 4, 1'b1, 1'b0);
    repeat (3) tick();
    chk("idle_after_gapped", {127'd0, busy}, 128'd0);

    // Reset after three words discards the partial key.
    do_start();
    send_key(k3, 3, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_reset_state("mid_reset");
    rst = 1'b1;
    tick();
    exp_wr.push_back(k3);
    do_start();
    send_key(k3, 4, 1'b0, 1'b0);
    repeat (3) tick();

`ifdef KEY_LOAD_CHECKSUM_EN
    // Wrong checksum word: err, no write.
    exp_err.push_back(1);
    do_start();
    send_key(k1, 4, 1'b0, 1'b1);
    tick();
    chk("chk_err", {127'd0, err}, 128'd1);
    tick();
`endif

    // Zeroize mid-load: zero write, no err, back to idle.
    exp_wr.push_back(128'd0);
    do_start();
    send_key(k2, 2, 1'b0, 1'b0);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk("zero_mid_we", {127'd0, ks_we}, 128'd1);
    chk("zero_mid_status", {125'd0, busy, err, locked}, 128'd0);
    tick();

    // Lock after two words: abort with err, sticky lock.
    exp_err.push_back(1);
    do_start();
    send_key(k1, 2, 1'b0, 1'b0);
    lock = 1'b1;
    tick();
    lock = 1'b0;
    chk("lock_abort", {125'd0, locked, err, busy}, 128'd6);
    tick();

    // Start while locked is rejected.
    exp_err.push_back(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("locked_start", {125'd0, err, busy, wr_ready}, 128'd4);
    tick();

    // Zeroize still works when locked; lock stays set.
    exp_wr.push_back(128'd0);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk("zero_locked", {126'd0, ks_we, locked}, 128'd3);
    repeat (3) tick();

    chk("pending_writes", 128'(exp_wr.size()), 128'd0);
    chk("pending_errs", 128'(exp_err.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
